// File: rtl/pixel_unpacker.sv
// Repacks 32-bit frame-buffer words into 24-bit RGB pixels (4 pixels per 3 words).
// Fetches words through a fixed-latency request handshake and streams pixels out valid/ready.
module pixel_unpacker #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned FRAME_PIXELS = 172800,
  parameter int unsigned FETCH_LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  output logic              word_req,
  input  logic              frame_start,
  input  logic              pixel_ready,
  output logic              pixel_valid,
  output logic [23:0]       pixel_rgb,
  output logic              frame_done
);

  typedef enum logic [1:0] {FIdle, FReq, FCap, FGap} fetch_state_e;

  localparam logic [16:0] WordLimit = 17'(FRAME_PIXELS * 3 / 4);
  localparam logic [17:0] PixLimit  = 18'(FRAME_PIXELS);
  localparam logic [7:0]  LatLast   = 8'(FETCH_LAT - 1);

  fetch_state_e state_q;
  logic [7:0]   lat_q;

  logic [7:0]  bytes_q [8];
  logic [7:0]  bytes_d [8];
  logic [7:0]  word_bytes [4];
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [16:0] word_cnt_q, word_cnt_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic        frame_done_q, frame_done_d;

  logic pop;
  logic cap;
  logic fetch_ok;

  assign pop        = pixel_valid && pixel_ready;
  assign cap        = (state_q == FCap);
  // byte_cnt can reach 8 (fetch starts at <=4), which exactly fills the buffer.
  assign fetch_ok   = (byte_cnt_q <= 4'd4) && (word_cnt_q < WordLimit) && !frame_done_q;
  assign frame_done = frame_done_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      word_bytes[k] = word_in[WORD_W-1-8*k -: 8];
    end
  end

  always_comb begin
    logic [3:0] cnt;
    bytes_d      = bytes_q;
    cnt          = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = frame_done_q;

    if (pop) begin
      for (int i = 0; i < 5; i++) begin
        bytes_d[i] = bytes_q[i+3];
      end
      for (int i = 5; i < 8; i++) begin
        bytes_d[i] = '0;
      end
      cnt       = byte_cnt_q - 4'd3;
      pix_cnt_d = pix_cnt_q + 18'd1;
      if (pix_cnt_d == PixLimit) begin
        frame_done_d = 1'b1;
      end
    end

    // New bytes land behind whatever survives a same-cycle pop.
    if (cap) begin
      for (int j = 0; j < 8; j++) begin
        if ((4'(j) >= cnt) && (4'(j) < cnt + 4'd4)) begin
          bytes_d[j] = word_bytes[2'(4'(j) - cnt)];
        end
      end
      cnt        = cnt + 4'd4;
      word_cnt_d = word_cnt_q + 17'd1;
    end

    byte_cnt_d = cnt;

    if (frame_start) begin
      for (int i = 0; i < 8; i++) begin
        bytes_d[i] = '0;
      end
      byte_cnt_d   = '0;
      word_cnt_d   = '0;
      pix_cnt_d    = '0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        bytes_q[i] <= '0;
      end
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_rgb    <= '0;
    end else begin
      bytes_q      <= bytes_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      pixel_valid  <= (byte_cnt_d >= 4'd3) && !frame_done_d;
      pixel_rgb    <= {bytes_d[0], bytes_d[1], bytes_d[2]};
    end
  end

  // Fetch sequencer; GAP chains straight into REQ so back-to-back words take FETCH_LAT+2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FIdle;
      lat_q    <= '0;
      word_req <= 1'b0;
    end else if (frame_start) begin
      state_q  <= FGap;
      lat_q    <= '0;
      word_req <= 1'b0;
    end else begin
      unique case (state_q)
        FIdle: begin
          if (fetch_ok) begin
            state_q  <= FReq;
            lat_q    <= '0;
            word_req <= 1'b1;
          end
        end
        FReq: begin
          lat_q <= lat_q + 8'd1;
          if (lat_q == LatLast) begin
            state_q  <= FCap;
            word_req <= 1'b0;
          end
        end
        FCap: begin
          state_q <= FGap;
        end
        FGap: begin
          if (fetch_ok) begin
            state_q  <= FReq;
            lat_q    <= '0;
            word_req <= 1'b1;
          end else begin
            state_q <= FIdle;
          end
        end
        default: begin
          state_q  <= FIdle;
          word_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
